// File: rtl/mc14500_seq.sv
// mc14500_seq: program sequencer for the MC14500B industrial control unit.
//
// Fetches program words over a req/ack handshake and presents each opcode to
// the ICU for exactly two cycles (EXEC, NEXT) with run_o high. The sequencer
// owns the program counter and a LIFO return stack. An ICU JMP is treated as a
// call: the return address is pushed, then the branch is taken. An ICU RTN
// pops the stack.
//
// Optional build macro: MC14500_SEQ_HALT_ON_NOPF_EN
//   defined   : FLAG_F seen in NEXT halts the sequencer (IDLE, PC advanced),
//               which gives a software halt/breakpoint. start_i resumes.
//   undefined : flag_f_i is ignored; NOPF is an ordinary no-op.
//
// Ports:
//   clk, RST          clock; asynchronous active-high reset
//   start_i, stop_i   begin execution (IDLE only) / halt after current instr
//   mem_req_o, mem_addr_o, mem_rdata_i, mem_ack_i   program-memory handshake
//   inst_o, run_o     opcode and run enable to the ICU
//   io_addr_o         address field of the current word (I/O or branch target)
//   jmp_i, rtn_i, flag_f_i   ICU JMP / RTN / FLAG_F outputs
//   busy_o, pc_o, sp_o       status: not idle, program counter, stack occupancy
//   ovf_o, unf_o      sticky call-overflow / return-underflow flags
`timescale 1ns/1ps

module mc14500_seq #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = 3
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [ADDR_W+3:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [3:0]        inst_o,
  output logic              run_o,
  output logic [ADDR_W-1:0] io_addr_o,
  input  logic              jmp_i,
  input  logic              rtn_i,
  input  logic              flag_f_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [SP_W-1:0]   sp_o,
  output logic              ovf_o,
  output logic              unf_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W+3:0] ir_q, ir_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              mem_req_q, mem_req_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic [3:0]        inst_q, inst_d;

  // Return stack: entry i is written when a push happens with sp == i.
  logic [ADDR_W-1:0]      stack_q [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] push_hit;
  logic                   push_en;
  logic [ADDR_W-1:0]      pc_inc;
  logic [ADDR_W-1:0]      pop_data;
  logic                   halt_req;

  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
  assign halt_req = flag_f_i;
`else
  logic unused_flag_f;
  assign unused_flag_f = flag_f_i;
  assign halt_req      = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_push_hit
      assign push_hit[gi] = push_en && (sp_q == SP_W'(gi));
    end
  endgenerate

  // Stack contents need no reset; only occupancy (sp) is architectural.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_hit[i]) begin
        stack_q[i] <= pc_inc;
      end
    end
  end

  // Top-of-stack read: the entry just below the stack pointer.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        pop_data = stack_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ir_d    = ir_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (jmp_i) begin
          // A call with a full stack still branches; only the push is lost.
          if (sp_q < SP_W'(STACK_DEPTH)) begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          pc_d = ir_q[ADDR_W-1:0];
        end else if (rtn_i) begin
          if (sp_q != '0) begin
            sp_d = sp_q - SP_W'(1);
            pc_d = pop_data;
          end else begin
            unf_d = 1'b1;
            pc_d  = '0;
          end
        end else begin
          pc_d = pc_inc;
        end
        state_d = (stop_i || halt_req) ? S_IDLE : S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, decoded from the state being entered.
    mem_req_d = (state_d == S_FETCH);
    run_d     = (state_d == S_EXEC) || (state_d == S_NEXT);
    busy_d    = (state_d != S_IDLE);
    inst_d    = run_d ? ir_d[ADDR_W+3:ADDR_W] : 4'h0;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      sp_q      <= '0;
      ir_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      mem_req_q <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      inst_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      ir_q      <= ir_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      mem_req_q <= mem_req_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
      inst_q    <= inst_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = pc_q;
  assign inst_o     = inst_q;
  assign run_o      = run_q;
  // The address field stays visible after the instruction completes.
  assign io_addr_o  = ir_q[ADDR_W-1:0];
  assign busy_o     = busy_q;
  assign pc_o       = pc_q;
  assign sp_o       = sp_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

endmodule

// File: tb/tb_mc14500_seq.sv
// tb_mc14500_seq: self-checking bench for mc14500_seq. Models the program
// memory (ack after a chosen number of wait cycles), a minimal ICU that raises
// JMP/RTN/FLAG_F from the presented opcode, and a reference sequencer built
// from a queue-based return stack.
`timescale 1ns/1ps

module tb_mc14500_seq;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int SPW   = 3;

  logic          clk = 1'b0;
  logic          RST;
  logic          start_i, stop_i, mem_ack_i;
  logic [AW+3:0] mem_rdata_i;
  logic          mem_req_o, run_o, busy_o, ovf_o, unf_o;
  logic [AW-1:0] mem_addr_o, io_addr_o, pc_o;
  logic [3:0]    inst_o;
  logic [SPW-1:0] sp_o;
  logic          jmp_i, rtn_i, flag_f_i;

  mc14500_seq #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .SP_W(SPW)) dut (
    .clk(clk), .RST(RST), .start_i(start_i), .stop_i(stop_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .inst_o(inst_o), .run_o(run_o), .io_addr_o(io_addr_o),
    .jmp_i(jmp_i), .rtn_i(rtn_i), .flag_f_i(flag_f_i), .busy_o(busy_o),
    .pc_o(pc_o), .sp_o(sp_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk = ~clk;

  // Minimal ICU: JMP=C, RTN=D, NOPF=F raise their outputs while running.
  assign jmp_i    = run_o && (inst_o == 4'hC);
  assign rtn_i    = run_o && (inst_o == 4'hD);
  assign flag_f_i = run_o && (inst_o == 4'hF);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf;

  // Observations from the most recent instruction.
  logic          obs_ok, obs_stable, obs_run_wait, obs_run_exec, obs_run_next;
  logic [AW-1:0] obs_addr, obs_io;
  logic [3:0]    obs_inst, obs_inst_next;

  function automatic void model_step(input logic [11:0] w);
    logic [3:0] op;
    op = w[11:8];
    if (op == 4'hC) begin
      if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 256);
      else m_ovf = 1'b1;
      m_pc = int'(w[7:0]);
    end else if (op == 4'hD) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_unf = 1'b1;
        m_pc  = 0;
      end
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endfunction

  // Random word whose opcode is neither JMP, RTN nor NOPF.
  function automatic logic [11:0] rand_nb();
    int op;
    op = $urandom_range(0, 12);
    if (op == 12) op = 14;
    return {4'(op), 8'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1; start_i = 1'b0; stop_i = 1'b0; mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    m_pc = 0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic start_seq();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Serve one fetch: wait for the request, hold ack low for 'waits' cycles,
  // then ack with 'word'. Returns on the falling edge after NEXT.
  task automatic do_instr(input logic [11:0] word, input int waits, input bit stop);
    obs_ok = 1'b0; obs_stable = 1'b1;
    for (int n = 0; n < 8 && mem_req_o !== 1'b1; n++) @(negedge clk);
    if (mem_req_o !== 1'b1) begin
      $display("[TB] no fetch request seen");
      return;
    end
    obs_addr = mem_addr_o;
    obs_run_wait = run_o;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      if (mem_addr_o !== obs_addr || mem_req_o !== 1'b1) obs_stable = 1'b0;
      if (run_o !== 1'b0) obs_run_wait = 1'b1;
    end
    mem_rdata_i = word; mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0; mem_rdata_i = 12'($urandom);
    obs_inst = inst_o; obs_io = io_addr_o; obs_run_exec = run_o;
    stop_i = stop;
    @(negedge clk);
    obs_run_next = run_o; obs_inst_next = inst_o;
    @(negedge clk);
    stop_i = 1'b0;
    obs_ok = 1'b1;
    $display("[TB] instr addr=%02h word=%03h waits=%0d stop=%0d", obs_addr, word, waits, stop);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({mem_req_o, run_o, busy_o, ovf_o, unf_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_req_o, run_o, busy_o, ovf_o, unf_o});
    end
    n_tests++;
    if ({inst_o, io_addr_o, mem_addr_o, pc_o, sp_o} !== '0) begin
      n_fail++; $display("FAIL reset_data inst=%h io=%h addr=%h pc=%h sp=%h exp=0", inst_o, io_addr_o, mem_addr_o, pc_o, sp_o);
    end
  endtask

  task automatic test_basic();
    logic [11:0] w;
    do_reset(); start_seq();
    do_instr(12'h105, 0, 1'b0);
    n_tests++;
    if ({obs_ok, obs_addr, obs_inst, obs_io} !== {1'b1, 8'(m_pc), 4'h1, 8'h05}) begin
      n_fail++; $display("FAIL basic_ld ok=%b addr=%h inst=%h io=%h exp addr=%h inst=1 io=05", obs_ok, obs_addr, obs_inst, obs_io, 8'(m_pc));
    end
    n_tests++;
    if ({obs_run_exec, obs_run_next, obs_inst_next, mem_req_o} !== {1'b1, 1'b1, 4'h1, 1'b1}) begin
      n_fail++; $display("FAIL basic_timing run=%b%b inst_next=%h req=%b exp 11 1 1", obs_run_exec, obs_run_next, obs_inst_next, mem_req_o);
    end
    model_step(12'h105);
    do_instr(12'h806, 0, 1'b0);
    n_tests++;
    if ({obs_addr, obs_inst, obs_io, mem_req_o} !== {8'(m_pc), 4'h8, 8'h06, 1'b1}) begin
      n_fail++; $display("FAIL basic_sto addr=%h inst=%h io=%h req=%b exp addr=%h inst=8 io=06 req=1", obs_addr, obs_inst, obs_io, mem_req_o, 8'(m_pc));
    end
    model_step(12'h806);
    w = rand_nb();
    do_instr(w, 0, 1'b1);
    n_tests++;
    if (obs_addr !== 8'h02) begin
      n_fail++; $display("FAIL basic_addr2 got=%h exp=02", obs_addr);
    end
    model_step(w);
    n_tests++;
    if ({busy_o, run_o, inst_o, pc_o, io_addr_o} !== {1'b0, 1'b0, 4'h0, 8'(m_pc), w[7:0]}) begin
      n_fail++; $display("FAIL basic_stop busy=%b run=%b inst=%h pc=%h io=%h exp 0 0 0 %h %h", busy_o, run_o, inst_o, pc_o, io_addr_o, 8'(m_pc), w[7:0]);
    end
  endtask

  task automatic test_call_return();
    logic [11:0] w;
    do_reset(); start_seq();
    for (int i = 0; i < 16; i++) begin
      w = rand_nb();
      do_instr(w, $urandom_range(0, 1), 1'b0);
      n_tests++;
      if (obs_addr !== 8'(m_pc)) begin
        n_fail++; $display("FAIL seq_addr got=%h exp=%h", obs_addr, 8'(m_pc));
      end
      model_step(w);
    end
    do_instr(12'hC40, 0, 1'b0);
    model_step(12'hC40);
    n_tests++;
    if ({obs_addr, sp_o, pc_o} !== {8'h10, 3'd1, 8'h40}) begin
      n_fail++; $display("FAIL call addr=%h sp=%0d pc=%h exp 10 1 40", obs_addr, sp_o, pc_o);
    end
    w = {4'hD, 8'($urandom)};
    do_instr(w, 0, 1'b0);
    model_step(w);
    n_tests++;
    if ({obs_addr, sp_o, pc_o} !== {8'h40, 3'd0, 8'h11}) begin
      n_fail++; $display("FAIL return addr=%h sp=%0d pc=%h exp 40 0 11", obs_addr, sp_o, pc_o);
    end
    w = rand_nb();
    do_instr(w, 0, 1'b1);
    n_tests++;
    if (obs_addr !== 8'(m_pc)) begin
      n_fail++; $display("FAIL return_fetch got=%h exp=%h", obs_addr, 8'(m_pc));
    end
    model_step(w);
  endtask

  task automatic test_overflow();
    logic [11:0] w;
    do_reset(); start_seq();
    for (int k = 1; k <= 5; k++) begin
      w = {4'hC, 8'($urandom)};
      do_instr(w, 0, 1'b0);
      n_tests++;
      if (obs_addr !== 8'(m_pc)) begin
        n_fail++; $display("FAIL ovf_addr%0d got=%h exp=%h", k, obs_addr, 8'(m_pc));
      end
      model_step(w);
      n_tests++;
      if ({sp_o, ovf_o} !== {3'(m_stack.size()), m_ovf}) begin
        n_fail++; $display("FAIL ovf_sp%0d sp=%0d ovf=%b exp sp=%0d ovf=%b", k, sp_o, ovf_o, m_stack.size(), m_ovf);
      end
    end
    n_tests++;
    if ({ovf_o, sp_o, pc_o} !== {1'b1, 3'd4, w[7:0]}) begin
      n_fail++; $display("FAIL ovf_final ovf=%b sp=%0d pc=%h exp 1 4 %h", ovf_o, sp_o, pc_o, w[7:0]);
    end
    w = rand_nb();
    do_instr(w, 0, 1'b1);
    model_step(w);
  endtask

  task automatic test_flags();
    logic [11:0] w;
    do_reset(); start_seq();
    w = {4'hD, 8'($urandom)};
    do_instr(w, 0, 1'b0);
    model_step(w);
    n_tests++;
    if ({unf_o, ovf_o, pc_o, mem_addr_o} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL unf unf=%b ovf=%b pc=%h addr=%h exp 1 0 00 00", unf_o, ovf_o, pc_o, mem_addr_o);
    end
    for (int k = 0; k < 5; k++) begin
      w = {4'hC, 8'($urandom)};
      do_instr(w, 0, k == 4);
      n_tests++;
      if (obs_addr !== 8'(m_pc)) begin
        n_fail++; $display("FAIL flags_addr got=%h exp=%h", obs_addr, 8'(m_pc));
      end
      model_step(w);
    end
    n_tests++;
    if ({busy_o, ovf_o, unf_o} !== {1'b0, m_ovf, m_unf}) begin
      n_fail++; $display("FAIL flags_idle busy=%b ovf=%b unf=%b exp 0 %b %b", busy_o, ovf_o, unf_o, m_ovf, m_unf);
    end
    start_seq();
    n_tests++;
    if ({ovf_o, unf_o, mem_req_o, mem_addr_o} !== {m_ovf, m_unf, 1'b1, 8'(m_pc)}) begin
      n_fail++; $display("FAIL flags_clear ovf=%b unf=%b req=%b addr=%h exp 0 0 1 %h", ovf_o, unf_o, mem_req_o, mem_addr_o, 8'(m_pc));
    end
    w = rand_nb();
    do_instr(w, 0, 1'b1);
    model_step(w);
  endtask

  task automatic test_wrap_wait();
    logic [11:0] w;
    do_reset(); start_seq();
    do_instr(12'hCFF, 0, 1'b0);
    model_step(12'hCFF);
    w = rand_nb();
    do_instr(w, 3, 1'b0);
    model_step(w);
    n_tests++;
    if ({obs_ok, obs_addr, obs_stable, obs_run_wait} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL wait ok=%b addr=%h stable=%b run_in_wait=%b exp 1 FF 1 0", obs_ok, obs_addr, obs_stable, obs_run_wait);
    end
    n_tests++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL wrap req=%b addr=%h exp 1 00", mem_req_o, mem_addr_o);
    end
    w = rand_nb();
    do_instr(w, 0, 1'b1);
    model_step(w);
  endtask

  task automatic test_nopf();
    logic [11:0] w;
    do_reset(); start_seq();
    do_instr(12'hC20, 0, 1'b0);
    model_step(12'hC20);
    w = {4'hF, 8'($urandom)};
    do_instr(w, 0, 1'b0);
    n_tests++;
    if ({obs_addr, obs_inst} !== {8'h20, 4'hF}) begin
      n_fail++; $display("FAIL nopf_fetch addr=%h inst=%h exp 20 F", obs_addr, obs_inst);
    end
    model_step(w);
`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
    n_tests++;
    if ({busy_o, mem_req_o, pc_o} !== {1'b0, 1'b0, 8'h21}) begin
      n_fail++; $display("FAIL nopf_halt busy=%b req=%b pc=%h exp 0 0 21", busy_o, mem_req_o, pc_o);
    end
    start_seq();
`else
    n_tests++;
    if ({busy_o, mem_req_o, mem_addr_o} !== {1'b1, 1'b1, 8'h21}) begin
      n_fail++; $display("FAIL nopf_noop busy=%b req=%b addr=%h exp 1 1 21", busy_o, mem_req_o, mem_addr_o);
    end
`endif
    w = rand_nb();
    do_instr(w, 0, 1'b1);
    n_tests++;
    if (obs_addr !== 8'h21) begin
      n_fail++; $display("FAIL nopf_resume got=%h exp=21", obs_addr);
    end
    model_step(w);
  endtask

  task automatic test_reset_mid_fetch();
    do_reset(); start_seq();
    do_instr({4'h3, 8'h5A}, 0, 1'b0);
    #1 RST = 1'b1;
    #1;
    n_tests++;
    if ({mem_req_o, run_o, busy_o, ovf_o, unf_o, inst_o, io_addr_o, mem_addr_o, pc_o, sp_o} !== '0) begin
      n_fail++; $display("FAIL async_rst req=%b run=%b busy=%b inst=%h io=%h addr=%h pc=%h exp all 0", mem_req_o, run_o, busy_o, inst_o, io_addr_o, mem_addr_o, pc_o);
    end
    mem_rdata_i = 12'h1AB; mem_ack_i = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    mem_ack_i = 1'b0;
    n_tests++;
    if ({busy_o, mem_req_o, run_o, io_addr_o} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL late_ack busy=%b req=%b run=%b io=%h exp 0 0 0 00", busy_o, mem_req_o, run_o, io_addr_o);
    end
    m_pc = 0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] w;
    do_reset(); start_seq();
    for (int i = 0; i < 40; i++) begin
      w = {4'($urandom_range(0, 14)), 8'($urandom)};
      do_instr(w, $urandom_range(0, 2), i == 39);
      n_tests++;
      if ({obs_ok, obs_addr, obs_inst} !== {1'b1, 8'(m_pc), w[11:8]}) begin
        n_fail++; $display("FAIL rand_fetch%0d ok=%b addr=%h inst=%h exp 1 %h %h", i, obs_ok, obs_addr, obs_inst, 8'(m_pc), w[11:8]);
      end
      model_step(w);
      n_tests++;
      if ({sp_o, ovf_o, unf_o, pc_o} !== {3'(m_stack.size()), m_ovf, m_unf, 8'(m_pc)}) begin
        n_fail++; $display("FAIL rand_state%0d sp=%0d ovf=%b unf=%b pc=%h exp %0d %b %b %h", i, sp_o, ovf_o, unf_o, pc_o, m_stack.size(), m_ovf, m_unf, 8'(m_pc));
      end
    end
  endtask

  initial begin
    RST = 1'b1; start_i = 1'b0; stop_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    test_reset();
    test_basic();
    test_call_return();
    test_overflow();
    test_flags();
    test_wrap_wait();
    test_nopf();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
